// File: rtl/i2c_pkg.sv
// Shared types and constants for the clocked I2C target with register file.
// Holds the FSM state encoding and the bus-level ACK and R/W bit values.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        WAIT_STOP
    } i2c_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // SDA is open drain, so a line level of 0 means pulling the pad low.
    function automatic logic oe_for(input logic line_level);
        return ~line_level;
    endfunction

endpackage

// File: rtl/i2c_slave_regfile_if.sv
// Pad-side I2C signals between the board-level open-drain buffers and the target.
interface i2c_slave_regfile_if;

    logic scl_i;
    logic sda_i;
    logic sda_oe;

    modport master (output scl_i, output sda_i, input sda_oe);
    modport slave  (input scl_i, input sda_i, output sda_oe);

endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into the clk domain and produces registered edge,
// START and STOP strobes that are aligned with a matching registered SDA sample.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
    logic scl_rise_q, scl_rise_d, scl_fall_q, scl_fall_d;
    logic sda_s_q, sda_s_d, start_q, start_d, stop_q, stop_d;
    logic scl_now, sda_now;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        scl_now    = scl_sync_q[SYNC_STAGES-1];
        sda_now    = sda_sync_q[SYNC_STAGES-1];
        scl_hist_d = scl_now;
        sda_hist_d = sda_now;
        scl_rise_d = scl_now & ~scl_hist_q;
        scl_fall_d = ~scl_now & scl_hist_q;
        sda_s_d    = sda_now;
        // SDA may only move while SCL is high at a START or STOP.
        start_d    = scl_now & scl_hist_q & sda_hist_q & ~sda_now;
        stop_d     = scl_now & scl_hist_q & ~sda_hist_q & sda_now;
    end

    // Idle bus level is high, so flops reset to 1 to avoid false edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            sda_s_q    <= 1'b1;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            sda_s_q    <= sda_s_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    assign scl_rise  = scl_rise_q;
    assign scl_fall  = scl_fall_q;
    assign sda_s     = sda_s_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;

endmodule

// File: rtl/i2c_slave_regfile.sv
// Clocked I2C target with a byte-wide register file, register pointer,
// auto-incrementing burst read/write and repeated START support.
module i2c_slave_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h2A,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    i2c_slave_regfile_if.slave          bus,
    input  logic [$clog2(NUM_REGS)-1:0] host_raddr,
    output logic [7:0]                  host_rdata,
    output logic                        wr_valid,
    output logic [$clog2(NUM_REGS)-1:0] wr_addr,
    output logic [7:0]                  wr_data,
    output logic                        busy
);

    localparam int         PW         = $clog2(NUM_REGS);
    localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

    logic scl_rise, scl_fall, sda_s, start_det, stop_det;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (bus.scl_i),
        .sda_i     (bus.sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_s     (sda_s),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_e    state_q;
    logic [3:0]    cnt_q;
    logic [7:0]    shift_q;
    logic [PW-1:0] ptr_q;
    logic          sda_oe_q, busy_q, wr_valid_q;
    logic [PW-1:0] wr_addr_q;
    logic [7:0]    wr_data_q;
    logic [7:0]    regs_q [NUM_REGS];

    logic [PW-1:0] ptr_inc;
    logic [7:0]    rd_byte, rd_next;
    logic          byte_done, ptr_ok;

    always_comb begin
        ptr_inc   = ptr_q + PW'(1);
        rd_byte   = regs_q[ptr_q];
        rd_next   = regs_q[ptr_inc];
        byte_done = (cnt_q == 4'd8);
        ptr_ok    = ({1'b0, shift_q} < NUM_REGS_W);
    end

    // Receive bits shift in on scl_rise; all SDA drive changes happen on scl_fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 8'd0;
            ptr_q      <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'd0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'd0;
        end else begin
            wr_valid_q <= 1'b0;
            if (stop_det) begin
                state_q  <= IDLE;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
                cnt_q    <= 4'd0;
            end else if (start_det) begin
                state_q  <= ADDR;
                sda_oe_q <= 1'b0;
                cnt_q    <= 4'd0;
            end else if (scl_rise) begin
                case (state_q)
                    ADDR, PTR, WDATA: begin
                        shift_q <= {shift_q[6:0], sda_s};
                        cnt_q   <= cnt_q + 4'd1;
                    end
                    RDATA_ACK: begin
                        if (sda_s == I2C_ACK) begin
                            ptr_q   <= ptr_inc;
                            shift_q <= rd_next;
                            cnt_q   <= 4'd8;
                            state_q <= RDATA;
                        end else begin
                            state_q <= WAIT_STOP;
                        end
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state_q)
                    ADDR: if (byte_done) begin
                        if (shift_q[7:1] == SLAVE_ADDR) begin
                            state_q  <= ADDR_ACK;
                            sda_oe_q <= oe_for(I2C_ACK);
                            busy_q   <= 1'b1;
                        end else begin
                            state_q  <= WAIT_STOP;
                            sda_oe_q <= oe_for(I2C_NACK);
                        end
                    end
                    ADDR_ACK: begin
                        cnt_q <= 4'd0;
                        case (shift_q[0])
                            RW_WRITE: begin
                                state_q  <= PTR;
                                sda_oe_q <= 1'b0;
                            end
                            RW_READ: begin
                                // First data bit goes out on the same fall that ends the ACK.
                                state_q  <= RDATA;
                                sda_oe_q <= oe_for(rd_byte[7]);
                                shift_q  <= {rd_byte[6:0], 1'b0};
                                cnt_q    <= 4'd7;
                            end
                            default: ;
                        endcase
                    end
                    PTR: if (byte_done) begin
                        cnt_q <= 4'd0;
                        if (ptr_ok) begin
                            ptr_q    <= shift_q[PW-1:0];
                            sda_oe_q <= oe_for(I2C_ACK);
                            state_q  <= PTR_ACK;
                        end else begin
                            sda_oe_q <= oe_for(I2C_NACK);
                            state_q  <= WAIT_STOP;
                        end
                    end
                    PTR_ACK: begin
                        sda_oe_q <= 1'b0;
                        cnt_q    <= 4'd0;
                        state_q  <= WDATA;
                    end
                    WDATA: if (byte_done) begin
                        regs_q[ptr_q] <= shift_q;
                        wr_valid_q    <= 1'b1;
                        wr_addr_q     <= ptr_q;
                        wr_data_q     <= shift_q;
                        sda_oe_q      <= oe_for(I2C_ACK);
                        cnt_q         <= 4'd0;
                        state_q       <= WDATA_ACK;
                    end
                    WDATA_ACK: begin
                        sda_oe_q <= 1'b0;
                        ptr_q    <= ptr_inc;
                        state_q  <= WDATA;
                    end
                    RDATA: begin
                        if (cnt_q != 4'd0) begin
                            sda_oe_q <= oe_for(shift_q[7]);
                            shift_q  <= {shift_q[6:0], 1'b0};
                            cnt_q    <= cnt_q - 4'd1;
                        end else begin
                            sda_oe_q <= 1'b0;
                            state_q  <= RDATA_ACK;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.sda_oe = sda_oe_q;
    assign host_rdata = regs_q[host_raddr];
    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: bit-bangs an open-drain I2C master and
// scoreboards write events and read bytes against a bench-side register model.
module tb_i2c_slave_regfile;

    localparam int Q = 80;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m;
    logic [3:0] host_raddr;
    logic [7:0] host_rdata;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  model_regs [16];
    logic [3:0]  tb_ptr;
    logic [11:0] wr_q [$];
    logic [7:0]  rd_q [$];
    logic        watch_oe = 1'b0;
    logic        oe_seen  = 1'b0;

    i2c_slave_regfile_if bus ();

    assign bus.scl_i = scl_m;
    assign bus.sda_i = sda_m & ~bus.sda_oe;

    i2c_slave_regfile #(
        .SLAVE_ADDR  (7'h2A),
        .NUM_REGS    (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .host_raddr (host_raddr),
        .host_rdata (host_rdata),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && wr_valid) begin
            if (wr_q.size() == 0) checkOutput("wr_unexpected", {31'd0, wr_valid}, 32'd0);
            else checkOutput("wr_event", {20'd0, wr_addr, wr_data}, {20'd0, wr_q.pop_front()});
        end
        if (watch_oe && bus.sda_oe) oe_seen = 1'b1;
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clockBit(input logic v, output logic s);
        sda_m = v;  #Q;
        scl_m = 1'b1; #Q;
        s = bus.sda_i; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2cStart();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2cStop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #(2*Q);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic exp_ack, input string tag);
        logic s, ack;
        for (int i = 7; i >= 0; i--) clockBit(b[i], s);
        clockBit(1'b1, ack);
        checkOutput(tag, {31'd0, ack}, {31'd0, exp_ack});
    endtask

    task automatic setPtr(input logic [7:0] p);
        applyStimulus(p, 1'b0, "ptr_ack");
        tb_ptr = p[3:0];
    endtask

    task automatic writeData(input logic [7:0] d);
        wr_q.push_back({tb_ptr, d});
        model_regs[tb_ptr] = d;
        applyStimulus(d, 1'b0, "wdata_ack");
        tb_ptr = tb_ptr + 4'd1;
    endtask

    task automatic readData(input logic ack_bit);
        logic s;
        logic [7:0] got;
        rd_q.push_back(model_regs[tb_ptr]);
        got = 8'd0;
        for (int i = 0; i < 8; i++) begin
            clockBit(1'b1, s);
            got = {got[6:0], s};
        end
        clockBit(ack_bit, s);
        checkOutput("rdata", {24'd0, got}, {24'd0, rd_q.pop_front()});
        if (ack_bit == 1'b0) tb_ptr = tb_ptr + 4'd1;
    endtask

    task automatic checkReg(input int idx, input string tag);
        @(negedge clk);
        host_raddr = 4'(idx);
        #2;
        checkOutput(tag, {24'd0, host_rdata}, {24'd0, model_regs[idx]});
    endtask

    initial begin
        logic s;
        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; host_raddr = 4'd0; tb_ptr = 4'd0;
        for (int i = 0; i < 16; i++) model_regs[i] = 8'd0;
        repeat (3) @(negedge clk);
        checkOutput("rst_sda_oe", {31'd0, bus.sda_oe}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        checkReg(0, "rst_reg0");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] burst write 0xA5, 0x3C at pointer 3");
        i2cStart();
        applyStimulus(8'h54, 1'b0, "addr_w_ack");
        checkOutput("busy_after_match", {31'd0, busy}, 32'd1);
        setPtr(8'h03);
        writeData(8'hA5);
        writeData(8'h3C);
        i2cStop();
        checkOutput("busy_after_stop", {31'd0, busy}, 32'd0);
        checkReg(3, "reg3");
        checkReg(4, "reg4");

        $display("[TB] wrong address 0x2B");
        watch_oe = 1'b1; oe_seen = 1'b0;
        i2cStart();
        applyStimulus(8'h56, 1'b1, "bad_addr_nack");
        applyStimulus(8'h11, 1'b1, "bad_addr_data_nack");
        i2cStop();
        watch_oe = 1'b0;
        checkOutput("bad_addr_oe_seen", {31'd0, oe_seen}, 32'd0);
        checkOutput("bad_addr_busy", {31'd0, busy}, 32'd0);
        checkReg(3, "reg3_unchanged");

        $display("[TB] burst write wrapping 15 -> 0");
        i2cStart();
        applyStimulus(8'h54, 1'b0, "addr_w_ack");
        setPtr(8'h0E);
        writeData(8'hE1);
        writeData(8'hF2);
        writeData(8'h0B);
        i2cStop();
        checkReg(0, "reg0_wrapped");

        $display("[TB] pointer 14, repeated START, burst read of 3");
        i2cStart();
        applyStimulus(8'h54, 1'b0, "addr_w_ack");
        setPtr(8'h0E);
        i2cStart();
        applyStimulus(8'h55, 1'b0, "addr_r_ack");
        readData(1'b0);
        readData(1'b0);
        readData(1'b1);
        checkOutput("rd_release", {31'd0, bus.sda_oe}, 32'd0);
        i2cStop();

        $display("[TB] read uses pointer left by write phase");
        i2cStart();
        applyStimulus(8'h54, 1'b0, "addr_w_ack");
        setPtr(8'h02);
        writeData(8'h66);
        i2cStart();
        applyStimulus(8'h55, 1'b0, "addr_r_ack");
        readData(1'b1);
        i2cStop();

        $display("[TB] out-of-range pointer 0x10");
        i2cStart();
        applyStimulus(8'h54, 1'b0, "addr_w_ack");
        applyStimulus(8'h10, 1'b1, "bad_ptr_nack");
        applyStimulus(8'h99, 1'b1, "wait_stop_nack");
        i2cStop();
        checkOutput("bad_ptr_busy", {31'd0, busy}, 32'd0);

        $display("[TB] reset while driving 3rd read bit low");
        i2cStart();
        applyStimulus(8'h54, 1'b0, "addr_w_ack");
        setPtr(8'h00);
        i2cStart();
        applyStimulus(8'h55, 1'b0, "addr_r_ack");
        clockBit(1'b1, s);
        clockBit(1'b1, s);
        checkOutput("rd_bit3_driven", {31'd0, bus.sda_oe}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_sda_oe", {31'd0, bus.sda_oe}, 32'd0);
        checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) model_regs[i] = 8'd0;
        tb_ptr = 4'd0;
        checkReg(0, "post_rst_reg0");
        checkReg(14, "post_rst_reg14");
        i2cStop();
        i2cStart();
        applyStimulus(8'h54, 1'b0, "addr_w_ack");
        setPtr(8'h05);
        writeData(8'h77);
        i2cStop();
        checkReg(5, "post_rst_reg5");
        i2cStart();
        applyStimulus(8'h54, 1'b0, "addr_w_ack");
        setPtr(8'h05);
        i2cStart();
        applyStimulus(8'h55, 1'b0, "addr_r_ack");
        readData(1'b1);
        i2cStop();

        $display("[TB] STOP in the middle of a data byte");
        i2cStart();
        applyStimulus(8'h54, 1'b0, "addr_w_ack");
        setPtr(8'h08);
        clockBit(1'b1, s);
        clockBit(1'b0, s);
        clockBit(1'b1, s);
        clockBit(1'b1, s);
        i2cStop();
        checkOutput("partial_busy", {31'd0, busy}, 32'd0);
        checkReg(8, "partial_reg8");
        i2cStart();
        applyStimulus(8'h54, 1'b0, "addr_w_ack");
        setPtr(8'h08);
        i2cStart();
        applyStimulus(8'h55, 1'b0, "addr_r_ack");
        readData(1'b1);
        i2cStop();

        repeat (10) @(negedge clk);
        checkOutput("wr_pending", wr_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
